// File: rtl/data_mem_param.sv
// Parametrised single-port data memory with LED register, range checking and sticky fault.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses are treated as out of range.
module data_mem_param #(
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR    = 32'h0000_2000,
  parameter int                    NUM_LEDS    = 8,
  parameter string                 INIT_FILE   = "programs/data.hex"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           write_data,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [3:0]            sign_mask,
  output logic [31:0]           read_data,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  clk_stall,
  output logic                  fault
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_READ_BUFFER = 2'd1,
    ST_READ        = 2'd2,
    ST_WRITE       = 2'd3
  } state_t;

  state_t                state_r, next_state_s;
  logic [31:0]           mem_r [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [2:0]            sm_r;      // {sign-extend, word, halfword-or-word}
  logic                  memread_r;
  logic [31:0]           word_r;
  logic [31:0]           led_reg_r;
  logic [31:0]           read_data_r;
  logic                  clk_stall_r;
  logic                  fault_r;

  logic [IW-1:0]         index_s;
  logic                  mem_hit_s, led_hit_s, misalign_s, mem_ok_s, led_ok_s;
  logic [31:0]           src_word_s, load_value_s, store_word_s;
  logic                  unused_s;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] sm);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    if (sm[1]) begin
      return w;
    end else if (sm[0]) begin
      return {{16{sm[2] & h[15]}}, h};
    end else begin
      return {{24{sm[2] & b[7]}}, b};
    end
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] lane, input logic [2:0] sm);
    logic [31:0] st;
    st = old;
    if (sm[1]) begin
      st = d;
    end else if (sm[0]) begin
      if (lane[1]) st[31:16] = d[15:0];
      else         st[15:0]  = d[15:0];
    end else begin
      case (lane)
        2'd0:    st[7:0]   = d[7:0];
        2'd1:    st[15:8]  = d[7:0];
        2'd2:    st[23:16] = d[7:0];
        2'd3:    st[31:24] = d[7:0];
        default: st        = old;
      endcase
    end
    return st;
  endfunction

  assign unused_s = sign_mask[0];

  // Address decode on the latched request; index is only meaningful when in range.
  always_comb begin
    index_s   = IW'((addr_r - BASE_ADDR) >> 2);
    mem_hit_s = ({1'b0, addr_r} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_r} < END_ADDR);
    led_hit_s = (addr_r[ADDR_WIDTH-1:2] == LED_ADDR[ADDR_WIDTH-1:2]);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_s = (sm_r[1] && (addr_r[1:0] != 2'b00)) || (!sm_r[1] && sm_r[0] && addr_r[0]);
`else
    misalign_s = 1'b0;
`endif
    led_ok_s  = led_hit_s && !misalign_s;
    mem_ok_s  = mem_hit_s && !led_hit_s && !misalign_s;
  end

  // Select the word being loaded from or merged into; out-of-range reads see zero.
  always_comb begin
    src_word_s = 32'd0;
    if (led_ok_s) begin
      src_word_s = led_reg_r;
    end else if (mem_ok_s) begin
      src_word_s = word_r;
    end else begin
      src_word_s = 32'd0;
    end
    load_value_s = load_fmt(src_word_s, addr_r[1:0], sm_r);
    store_word_s = store_merge(src_word_s, wdata_r, addr_r[1:0], sm_r);
  end

  // Next-state logic; a simultaneous read and write resolves to the read.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (memread || memwrite) next_state_s = ST_READ_BUFFER;
        else                     next_state_s = ST_IDLE;
      end
      ST_READ_BUFFER: begin
        if (memread_r) next_state_s = ST_READ;
        else           next_state_s = ST_WRITE;
      end
      ST_READ:  next_state_s = ST_IDLE;
      ST_WRITE: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Request capture while idle; requests arriving during a stall are ignored.
  always_ff @(posedge clk) begin
    if (state_r == ST_IDLE) begin
      addr_r    <= addr;
      wdata_r   <= write_data;
      sm_r      <= sign_mask[3:1];
      memread_r <= memread;
    end
  end

  // Block-RAM port: buffered read, then commit of the merged word.
  always_ff @(posedge clk) begin
    if (state_r == ST_READ_BUFFER) word_r <= mem_r[index_s];
    if (!reset && (state_r == ST_WRITE) && mem_ok_s) mem_r[index_s] <= store_word_s;
  end

  // Registered outputs: stall handshake, load result, LED register and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_stall_r <= 1'b0;
      read_data_r <= 32'd0;
      led_reg_r   <= 32'd0;
      fault_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: clk_stall_r <= memread || memwrite;
        ST_READ_BUFFER: clk_stall_r <= 1'b1;
        ST_READ: begin
          read_data_r <= load_value_s;
          clk_stall_r <= 1'b0;
          if (!(mem_ok_s || led_ok_s)) fault_r <= 1'b1;
        end
        ST_WRITE: begin
          if (led_ok_s) led_reg_r <= store_word_s;
          clk_stall_r <= 1'b0;
          if (!(mem_ok_s || led_ok_s)) fault_r <= 1'b1;
        end
        default: clk_stall_r <= 1'b0;
      endcase
    end
  end

  assign read_data = read_data_r;
  assign led       = led_reg_r[NUM_LEDS-1:0];
  assign clk_stall = clk_stall_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: constant vector table, reset/handshake sequences and a
// randomized phase checked against a byte-addressed reference model.
module tb_data_mem_param;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LEDA  = 32'h0000_2000;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;
  logic        fault;

  data_mem_param #(
    .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .LED_ADDR(LEDA),
    .NUM_LEDS(8), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .led(led), .clk_stall(clk_stall), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: little-endian byte array, LED bytes and sticky fault.
  logic [7:0] mb [DEPTH*4];
  logic [7:0] ledb [4];
  bit         exp_fault;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [3:0]  sm;
    logic        chk;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_fault;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] sm, output int st);
    @(negedge clk);
    addr = a; write_data = wd; sign_mask = sm; memread = rd; memwrite = wr;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    st = 0;
    while (clk_stall && st < 10) begin
      st++;
      @(posedge clk); #1;
    end
  endtask

  function automatic int nbytes(input logic [3:0] sm);
    return sm[2] ? 4 : (sm[1] ? 2 : 1);
  endfunction

  // 0 = array, 1 = LED register, 2 = out of range
  function automatic int kind_of(input logic [31:0] a, input logic [3:0] sm);
    int n = nbytes(sm);
    if (TRAP && (a % n) != 0) return 2;
    if ((a >> 2) == (LEDA >> 2)) return 1;
    if (a >= BASE && a < BASE + 4 * DEPTH) return 0;
    return 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] sm);
    int n = nbytes(sm);
    int k = kind_of(a, sm);
    longint unsigned v = 0;
    logic [31:0] b = a & ~(n - 1);
    if (k == 2) return 32'd0;
    for (int i = 0; i < n; i++)
      v |= longint'(k == 0 ? mb[b + i - BASE] : ledb[(b + i) % 4]) << (8 * i);
    if (sm[3] && ((v >> (8 * n - 1)) & 1) == 1) v |= ~((64'd1 << (8 * n)) - 1);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
    int n = nbytes(sm);
    int k = kind_of(a, sm);
    logic [31:0] b = a & ~(n - 1);
    for (int i = 0; i < n; i++) begin
      if (k == 0) mb[b + i - BASE] = 8'(wd >> (8 * i));
      else if (k == 1) ledb[(b + i) % 4] = 8'(wd >> (8 * i));
    end
  endtask

  task automatic run_op(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sm);
    logic [31:0] exp_rd;
    int st;
    exp_rd = model_load(a, sm);
    if (kind_of(a, sm) == 2) exp_fault = 1'b1;
    if (!rd && wr) model_store(a, wd, sm);
    do_access(rd, wr, a, wd, sm, st);
    check({name, " stall"}, 32'(st), 32'd2);
    if (rd) check({name, " rdata"}, read_data, exp_rd);
    check({name, " led"}, {24'd0, led}, {24'd0, ledb[0]});
    check({name, " fault"}, {31'd0, fault}, {31'd0, exp_fault});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int st;
    logic [31:0] a;
    logic [3:0]  sm;
    int r, sz;

    reset = 1'b1; addr = 32'd0; write_data = 32'd0; memwrite = 1'b0; memread = 1'b0;
    sign_mask = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset stall", {31'd0, clk_stall}, 32'd0);
    check("reset rdata", read_data, 32'd0);
    check("reset led", {24'd0, led}, 32'd0);
    check("reset fault", {31'd0, fault}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Reset in the middle of a store: nothing committed, outputs cleared.
    do_access(1'b0, 1'b1, BASE, 32'h1111_1111, 4'b0111, st);
    do_access(1'b0, 1'b1, LEDA, 32'h0000_005A, 4'b0001, st);
    do_access(1'b1, 1'b0, BASE, 32'd0, 4'b0111, st);
    check("pre-reset rdata", read_data, 32'h1111_1111);
    @(negedge clk);
    addr = BASE; write_data = 32'h2222_2222; sign_mask = 4'b0111; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset stall", {31'd0, clk_stall}, 32'd0);
    check("midreset rdata", read_data, 32'd0);
    check("midreset led", {24'd0, led}, 32'd0);
    check("midreset fault", {31'd0, fault}, 32'd0);
    @(negedge clk) reset = 1'b0;
    do_access(1'b1, 1'b0, BASE, 32'd0, 4'b0111, st);
    check("midreset word0", read_data, 32'h1111_1111);
    check("midreset stall count", 32'(st), 32'd2);

    vec[0]  = '{1'b0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0111, 1'b0, 32'h0,         8'h00, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 32'h1007, 32'h0,         4'b1001, 1'b1, 32'hFFFF_FFDE, 8'h00, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 32'h1007, 32'h0,         4'b0001, 1'b1, 32'h0000_00DE, 8'h00, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 32'h1006, 32'h0000_1234, 4'b0011, 1'b0, 32'h0,         8'h00, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'b0111, 1'b1, 32'h1234_BEEF, 8'h00, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'b1011, 1'b1, 32'hFFFF_BEEF, 8'h00, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 32'h2000, 32'h0000_00A5, 4'b0001, 1'b0, 32'h0,         8'hA5, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 32'h2000, 32'h0,         4'b0111, 1'b1, 32'h0000_00A5, 8'hA5, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'b0111, 1'b1, 32'h1234_BEEF, 8'hA5, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 32'h1008, 32'h0BAD_F00D, 4'b0111, 1'b0, 32'h0,         8'hA5, 1'b0};
    vec[10] = '{1'b1, 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'b0111, 1'b1, 32'h0BAD_F00D, 8'hA5, 1'b0};
    vec[11] = '{1'b1, 1'b0, 32'h1008, 32'h0,         4'b0111, 1'b1, 32'h0BAD_F00D, 8'hA5, 1'b0};
    vec[12] = '{1'b1, 1'b0, 32'h1002, 32'h0,         4'b0111, 1'b1,
                TRAP ? 32'h0 : 32'h1111_1111, 8'hA5, TRAP};
    vec[13] = '{1'b1, 1'b0, 32'h1400, 32'h0,         4'b0111, 1'b1, 32'h0,         8'hA5, 1'b1};
    vec[14] = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'b0111, 1'b1, 32'h1234_BEEF, 8'hA5, 1'b1};

    for (int i = 0; i < 15; i++) begin
      do_access(vec[i].rd, vec[i].wr, vec[i].a, vec[i].wd, vec[i].sm, st);
      check($sformatf("vec%0d stall", i), 32'(st), 32'd2);
      if (vec[i].chk) check($sformatf("vec%0d rdata", i), read_data, vec[i].exp_rd);
      check($sformatf("vec%0d led", i), {24'd0, led}, {24'd0, vec[i].exp_led});
      check($sformatf("vec%0d fault", i), {31'd0, fault}, {31'd0, vec[i].exp_fault});
    end

    // Only reset clears the sticky fault.
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("fault cleared", {31'd0, fault}, 32'd0);
    check("led cleared", {24'd0, led}, 32'd0);
    @(negedge clk) reset = 1'b0;

    exp_fault = 1'b0;
    for (int i = 0; i < 4; i++) ledb[i] = 8'h00;
    for (int w = 0; w < DEPTH; w++)
      run_op("fill", 1'b0, 1'b1, BASE + 4 * w, $urandom, 4'b0111);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + $urandom_range(0, 4 * DEPTH - 1);
      else if (r == 8) a = LEDA + $urandom_range(0, 3);
      else begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'd4;
          1:       a = BASE + 4 * DEPTH;
          2:       a = 32'h0000_3000 + $urandom_range(0, 255);
          default: a = 32'hFFFF_FFFC;
        endcase
      end
      sz = $urandom_range(0, 2);
      sm = {1'($urandom_range(0, 1)), sz == 2, sz >= 1, 1'b1};
      case ($urandom_range(0, 4))
        0, 1:    run_op("rand load", 1'b1, 1'b0, a, 32'd0, sm);
        2, 3:    run_op("rand store", 1'b0, 1'b1, a, $urandom, sm);
        default: run_op("rand both", 1'b1, 1'b1, a, $urandom, sm);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
